sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Downstream consumer of the 4-bit adder stage. It takes the adder's `io_sum` results as a valid/ready stream, accumulates a frame of sums into a wider register with a term count and a sticky overflow flag, and presents each completed frame total on a valid/ready output. It sits between the adder stage and any block that consumes reduced (summed) results.

## Interface

**Parameters**
- `WIDTH`, 4: width of incoming sum; matches adder `io_sum`.
- `ACC_WIDTH`, 8: accumulator width; must be ≥ `WIDTH`.
- `COUNT_MAX`, 8: maximum terms per frame; must be ≥ 1.
- `CW`, derived, equals ceil(log2(`COUNT_MAX`+1)), which is 4 at defaults.

**Ports**
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; reset applied when low at a rising edge.
- `io_in_valid`  in  1  upstream sum beat valid.
- `io_in_ready`  out  1  block accepts a beat this cycle.
- `io_in_sum`  in  `WIDTH`  unsigned sum from adder stage.
- `io_in_last`  in  1  beat terminates current frame.
- `io_out_valid`  out  1  frame result valid.
- `io_out_ready`  in  1  downstream accepts result.
- `io_out_acc`  out  `ACC_WIDTH`  frame total, modulo 2^`ACC_WIDTH`.
- `io_out_count`  out  `CW`  number of beats in frame (1..`COUNT_MAX`).
- `io_out_ovf`  out  1  sticky: some accumulation in frame carried out of `ACC_WIDTH`.

## Operation

- **States:** IDLE, ACCUM, HOLD. `acc`, `cnt`, and `ovf` are registers.
- **Accept:** a beat is accepted when `io_in_valid && io_in_ready`. `io_in_ready` = 1 in IDLE and ACCUM, 0 in HOLD.
- **IDLE, on accept:**
  - `acc` = zero-extended `io_in_sum`; `cnt` = 1; `ovf` = 0.
  - The terminating condition is `io_in_last` = 1 or `COUNT_MAX` = 1.
  - If terminating, go to HOLD; else go to ACCUM.
- **ACCUM, on accept:**
  - `acc` = (`acc` + zext(`io_in_sum`)) mod 2^`ACC_WIDTH`.
  - `ovf` |= carry out of bit `ACC_WIDTH`-1.
  - `cnt` += 1.
  - If `io_in_last` = 1 or the new `cnt` = `COUNT_MAX`, go to HOLD.
  - With no accept, state holds.
- **Frame length cap:** the beat that brings `cnt` to `COUNT_MAX` ends the frame even with `io_in_last` = 0. The next beat starts a new frame.
- **HOLD:**
  - `io_out_valid` = 1; outputs show `acc`, `cnt`, `ovf` and stay stable until handshake.
  - On `io_out_ready` = 1, go to IDLE.
  - `io_out_valid` must not drop without a handshake.
- **Outputs in IDLE/ACCUM:** `io_out_valid` = 0. `io_out_acc`, `io_out_count`, and `io_out_ovf` reflect the registers but are don't-care to consumers.
- **Reset:** when `reset` = 0 at an edge, go to IDLE with `acc` = 0, `cnt` = 0, `ovf` = 0. This applies from any state, including mid-frame (partial frame discarded) and HOLD (pending result dropped, no handshake).
- **Reset values of outputs:** `io_in_ready` = 1, `io_out_valid` = 0, `io_out_acc` = 0, `io_out_count` = 0, `io_out_ovf` = 0.
- **Arithmetic:** all values unsigned; there is no saturation.

## Timing

- **Result latency:** `io_out_valid` rises in the cycle after the edge that accepts the terminating beat.
- **Throughput:** one beat per cycle while not in HOLD. A frame of N beats with immediate `io_out_ready` occupies N+1 cycles.
- **Back-to-back frames:** `io_in_ready` returns to 1 the cycle after the output handshake edge. There is no input/output overlap in the same cycle.
- **Combinational paths:** `io_in_ready` and all `io_out_*` are register-decoded only. There is no combinational path from `io_in_*` or `io_out_ready`.
- **Simultaneous reset and handshake:** reset wins. The result is considered not delivered.

## Test plan

- **Three-beat frame:** reset low 2 cycles, then high; drive sums 3, 5, 7 with `last` on 7, `io_out_ready` = 1. Expect `io_out_acc` = 15, `count` = 3, `ovf` = 0; `io_out_valid` high the cycle after the 7 is accepted, for exactly 1 cycle.
- **Length cap:** drive 8 beats of sum 15 with `last` = 0 throughout. Expect frame closes at beat 8 with `acc` = 120, `count` = 8, `ovf` = 0. A 9th beat starts a new frame with `count` = 1.
- **Overflow wrap (`ACC_WIDTH` = 4 override):** drive sums 9 and 9 with `last`. Expect `acc` = 2, `ovf` = 1, `count` = 2.
- **Backpressure:** frame {4, last} with `io_out_ready` = 0 for 5 cycles. Expect `io_out_valid` held high with `acc` = 4 stable and `io_in_ready` = 0 throughout. Release ready and expect `io_in_ready` = 1 the next cycle.
- **Single-beat and random valid gaps:** frame {6, last}, then frame {1, 2, last} with `in_valid` toggling randomly. Expect results 6/1 and 3/2 in order, with no beat lost or duplicated.
- **Reset mid-frame and in HOLD:**
  - Accept 5 and 6, then pull reset low 1 cycle. Expect all outputs at reset values and no result emitted. Then {2, last} yields `acc` = 2, `count` = 1.
  - Repeat with reset asserted while in HOLD. Expect `io_out_valid` = 0 after the edge.

Source files
------------

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//
// Reduces a valid/ready stream of unsigned adder-stage sums into per-frame
// totals. A frame ends on a beat carrying io_in_last, or on the beat that
// brings the term count to COUNT_MAX. Each completed frame is presented on a
// valid/ready output: the wrapped total, the term count and a sticky flag
// that records any carry out of the accumulator during the frame.
//
// Parameters
//   WIDTH      width of the incoming sum
//   ACC_WIDTH  accumulator width (>= WIDTH)
//   COUNT_MAX  maximum beats per frame (>= 1)
//   CW         derived count width, ceil(log2(COUNT_MAX+1))
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   io_in_valid   upstream beat valid
//   io_in_ready   beat accepted this cycle when valid (low while a result waits)
//   io_in_sum     unsigned sum beat
//   io_in_last    beat terminates the current frame
//   io_out_valid  frame result valid
//   io_out_ready  downstream accepts the result
//   io_out_acc    frame total modulo 2^ACC_WIDTH
//   io_out_count  number of beats in the frame
//   io_out_ovf    some accumulation in the frame carried out of ACC_WIDTH
// -----------------------------------------------------------------------------
module sum_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT_MAX = 8,
  localparam int CW       = $clog2(COUNT_MAX + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WIDTH-1:0]     io_in_sum,
  input  logic                 io_in_last,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [ACC_WIDTH-1:0] io_out_acc,
  output logic [CW-1:0]        io_out_count,
  output logic                 io_out_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [CW-1:0] ONE_C   = CW'(32'd1);
  localparam logic [CW-1:0] CAP_C   = CW'(COUNT_MAX);
  // With a one-beat cap every accepted beat closes its frame.
  localparam bit            CAP_ONE = (COUNT_MAX == 32'sd1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 in_ready_s;
  logic                 accept_s;
  logic [ACC_WIDTH-1:0] sum_ext_s;
  logic [ACC_WIDTH:0]   add_s;
  logic [CW-1:0]        cnt_inc_s;

  // Handshake decode and datapath helpers; the extra MSB of add_s is the carry.
  always_comb begin
    in_ready_s = (state_q != ST_HOLD);
    accept_s   = io_in_valid & in_ready_s;
    sum_ext_s  = ACC_WIDTH'(io_in_sum);
    add_s      = {1'b0, acc_q} + {1'b0, sum_ext_s};
    cnt_inc_s  = cnt_q + ONE_C;
  end

  // Next-state and register-update logic for the frame FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          acc_d = sum_ext_s;
          cnt_d = ONE_C;
          ovf_d = 1'b0;
          if (io_in_last || CAP_ONE) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_d = add_s[ACC_WIDTH-1:0];
          ovf_d = ovf_q | add_s[ACC_WIDTH];
          cnt_d = cnt_inc_s;
          if (io_in_last || (cnt_inc_s == CAP_C)) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        // Result registers stay frozen until the consumer takes them.
        if (io_out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = {ACC_WIDTH{1'b0}};
        cnt_d   = {CW{1'b0}};
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and accumulator registers; reset discards any partial or pending frame.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      acc_q   <= {ACC_WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are decoded from registers only.
  always_comb begin
    io_in_ready  = in_ready_s;
    io_out_valid = (state_q == ST_HOLD);
    io_out_acc   = acc_q;
    io_out_count = cnt_q;
    io_out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//
// Directed bench for sum_accumulator. A default-parameter instance carries the
// table-driven frames and the multi-cycle sequences; a second instance with a
// 4-bit accumulator exercises the wrap/overflow flag.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

  logic       clock;
  logic       reset;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sum;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_acc;
  logic [3:0] out_count;
  logic       out_ovf;

  logic       d2_in_valid;
  logic       d2_in_ready;
  logic [3:0] d2_in_sum;
  logic       d2_in_last;
  logic       d2_out_valid;
  logic       d2_out_ready;
  logic [3:0] d2_out_acc;
  logic [3:0] d2_out_count;
  logic       d2_out_ovf;

  int checks = 0;
  int errors = 0;

  sum_accumulator dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_sum    (in_sum),
    .io_in_last   (in_last),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_acc   (out_acc),
    .io_out_count (out_count),
    .io_out_ovf   (out_ovf)
  );

  sum_accumulator #(.ACC_WIDTH(4)) dut_w4 (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (d2_in_valid),
    .io_in_ready  (d2_in_ready),
    .io_in_sum    (d2_in_sum),
    .io_in_last   (d2_in_last),
    .io_out_valid (d2_out_valid),
    .io_out_ready (d2_out_ready),
    .io_out_acc   (d2_out_acc),
    .io_out_count (d2_out_count),
    .io_out_ovf   (d2_out_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       l;
    logic       r;
    logic       e_in_ready;
    logic       e_out_valid;
    logic       chk_data;
    logic [7:0] e_acc;
    logic [3:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [3:0] s, input logic l,
                              input logic r, input logic e_in_ready,
                              input logic e_out_valid, input logic chk_data,
                              input logic [7:0] e_acc, input logic [3:0] e_cnt,
                              input logic e_ovf);
    vec_t t;
    t.v = v; t.s = s; t.l = l; t.r = r;
    t.e_in_ready = e_in_ready; t.e_out_valid = e_out_valid;
    t.chk_data = chk_data; t.e_acc = e_acc; t.e_cnt = e_cnt; t.e_ovf = e_ovf;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic l, input logic r);
    in_valid  = v;
    in_sum    = s;
    in_last   = l;
    out_ready = r;
  endtask

  logic [3:0] rb_sum[3];
  logic       rb_last[3];
  logic [7:0] exp_acc_q[$];
  logic [3:0] exp_cnt_q[$];

  initial begin
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    d2_in_valid = 1'b0; d2_in_sum = 4'd0; d2_in_last = 1'b0; d2_out_ready = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc", out_acc, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_w4_valid", d2_out_valid, 0);
    reset = 1'b1;

    // ---------------- table: three-beat, length cap, single beat ----------------
    //                  v     s      l     r     rdy   oval  chk   acc     cnt   ovf
    vecs.push_back(mk(1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 4'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd15,  4'd3, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4'd0, 1'b0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd120, 4'd8, 1'b0));
    // Offered while holding: not accepted, frame handshakes out.
    vecs.push_back(mk(1'b1, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4'd0, 1'b0));
    // Ninth beat opens a fresh frame.
    vecs.push_back(mk(1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd15,  4'd1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 4'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd6,   4'd1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4'd0, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].l, vecs[i].r);
      tick();
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_out_valid);
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_acc", i), out_acc, vecs[i].e_acc);
        check($sformatf("vec%0d_count", i), out_count, vecs[i].e_cnt);
        check($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].e_ovf);
      end
    end

    // ---------------- backpressure ----------------
    drive(1'b1, 4'd4, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_out_valid", c), out_valid, 1);
      check($sformatf("bp%0d_acc", c), out_acc, 4);
      check($sformatf("bp%0d_in_ready", c), in_ready, 0);
      if (c < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // ---------------- random valid gaps ----------------
    rb_sum[0] = 4'd6; rb_last[0] = 1'b1;
    rb_sum[1] = 4'd1; rb_last[1] = 1'b0;
    rb_sum[2] = 4'd2; rb_last[2] = 1'b1;
    exp_acc_q.push_back(8'd6); exp_cnt_q.push_back(4'd1);
    exp_acc_q.push_back(8'd3); exp_cnt_q.push_back(4'd2);
    begin
      int  bi;
      logic v;
      logic rdy;
      bi = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (bi >= 3 && exp_acc_q.size() == 0) break;
        v = (bi < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive(v, (bi < 3) ? rb_sum[bi] : 4'd0, (bi < 3) ? rb_last[bi] : 1'b0, 1'b1);
        rdy = in_ready;
        tick();
        if (v && rdy) bi++;
        if (out_valid) begin
          if (exp_acc_q.size() == 0) begin
            check("gap_extra_result", 1, 0);
          end else begin
            check("gap_acc", out_acc, exp_acc_q.pop_front());
            check("gap_count", out_count, exp_cnt_q.pop_front());
            check("gap_ovf", out_ovf, 0);
          end
        end
      end
      check("gap_results_pending", exp_acc_q.size(), 0);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    tick();

    // ---------------- reset mid-frame ----------------
    drive(1'b1, 4'd5, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd6, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rmid_in_ready", in_ready, 1);
    check("rmid_out_valid", out_valid, 0);
    check("rmid_acc", out_acc, 0);
    check("rmid_count", out_count, 0);
    check("rmid_ovf", out_ovf, 0);
    drive(1'b1, 4'd2, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    check("rmid_next_valid", out_valid, 1);
    check("rmid_next_acc", out_acc, 2);
    check("rmid_next_count", out_count, 1);
    tick();
    check("rmid_next_done", out_valid, 0);

    // ---------------- reset while holding (with simultaneous handshake) ----------------
    drive(1'b1, 4'd9, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    check("rhold_valid_before", out_valid, 1);
    check("rhold_acc_before", out_acc, 9);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rhold_out_valid", out_valid, 0);
    check("rhold_in_ready", in_ready, 1);
    check("rhold_acc", out_acc, 0);
    check("rhold_count", out_count, 0);
    tick();
    check("rhold_stays_idle", out_valid, 0);

    // ---------------- overflow wrap on 4-bit accumulator ----------------
    d2_in_valid = 1'b1; d2_in_sum = 4'd9; d2_in_last = 1'b0;
    tick();
    d2_in_last = 1'b1;
    tick();
    d2_in_valid = 1'b0; d2_in_last = 1'b0;
    check("w4_valid", d2_out_valid, 1);
    check("w4_acc", d2_out_acc, 2);
    check("w4_count", d2_out_count, 2);
    check("w4_ovf", d2_out_ovf, 1);
    tick();
    d2_in_valid = 1'b1; d2_in_sum = 4'd1; d2_in_last = 1'b1;
    tick();
    d2_in_valid = 1'b0; d2_in_last = 1'b0;
    check("w4_next_acc", d2_out_acc, 1);
    check("w4_next_ovf", d2_out_ovf, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
